// File: rtl/simon_pkg.sv
// Shared SIMON32/64 definitions used by the key expansion, encrypt and decrypt blocks.
package simon_pkg;
  localparam int ROUNDS = 32;
  localparam int WORD   = 16;

  // Round-constant sequence z0. Bit i holds z0[i]; the key schedule consumes it LSB first.
  localparam logic [61:0] Z0 = 62'h19C3522FB386A45F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_KEY,
    ST_RUN,
    ST_DONE
  } state_e;

  // SIMON round function: (v <<< 1 & v <<< 8) ^ (v <<< 2)
  function automatic logic [WORD-1:0] f(input logic [WORD-1:0] v);
    logic [WORD-1:0] r1, r2, r8;
    r1 = {v[WORD-2:0], v[WORD-1]};
    r2 = {v[WORD-3:0], v[WORD-1:WORD-2]};
    r8 = {v[WORD-9:0], v[WORD-1:WORD-8]};
    return (r1 & r8) ^ r2;
  endfunction
endpackage

// File: rtl/simon32_decrypt_if.sv
// Ciphertext-in / plaintext-out handshake bundle for the SIMON32 decrypt block.
interface simon32_decrypt_if;
  import simon_pkg::*;

  logic              ct_valid;
  logic              ct_ready;
  logic [2*WORD-1:0] ct_in;
  logic              pt_valid;
  logic              pt_ready;
  logic [2*WORD-1:0] pt_out;

  // master drives ciphertext and consumes plaintext; slave is the decrypt core
  modport master (output ct_valid, ct_in, pt_ready,
                  input  ct_ready, pt_valid, pt_out);
  modport slave  (input  ct_valid, ct_in, pt_ready,
                  output ct_ready, pt_valid, pt_out);
endinterface

// File: rtl/simon_round_inv.sv
// One inverse SIMON round, purely combinational.
module simon_round_inv #(
  parameter int WORD = 16
) (
  input  logic [WORD-1:0] x_i,
  input  logic [WORD-1:0] y_i,
  input  logic [WORD-1:0] k_i,
  output logic [WORD-1:0] x_o,
  output logic [WORD-1:0] y_o
);
  import simon_pkg::*;

  // Undo one forward round: the old x reappears as y, the old y is recovered from x.
  assign x_o = y_i;
  assign y_o = x_i ^ f(y_i) ^ k_i;
endmodule

// File: rtl/simon32_decrypt.sv
// SIMON32/64 iterative decryptor: one inverse round per cycle, rounds 31 down to 0,
// waiting on the key expansion block's per-round valid flags.
module simon32_decrypt #(
  parameter int ROUNDS = 32,
  parameter int WORD   = 16
) (
  input  logic            clk,
  input  logic            rst,
  simon32_decrypt_if.slave bus,
  input  logic [WORD-1:0] k_in      [ROUNDS],
  input  logic            key_ready [ROUNDS],
  output logic            busy
);
  import simon_pkg::*;

  localparam int RW = $clog2(ROUNDS);
  localparam logic [RW-1:0] R_LAST = RW'(ROUNDS - 1);

  state_e            state_q, state_d;
  logic [WORD-1:0]   x_q, x_d, y_q, y_d;
  logic [2*WORD-1:0] ctx_q, ctx_d;       // untouched ciphertext for round restarts
  logic [RW-1:0]     r_q, r_d;
  logic [2*WORD-1:0] pt_out_q, pt_out_d;
  logic              pt_valid_q, pt_valid_d;
  logic [WORD-1:0]   rnd_x, rnd_y;

  simon_round_inv #(.WORD(WORD)) u_round (
    .x_i (x_q),
    .y_i (y_q),
    .k_i (k_in[r_q]),
    .x_o (rnd_x),
    .y_o (rnd_y)
  );

  // Next-state: handshake capture, key wait, round iteration and output hold
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    ctx_d      = ctx_q;
    r_d        = r_q;
    pt_out_d   = pt_out_q;
    pt_valid_d = pt_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.ct_valid) begin
          {x_d, y_d} = bus.ct_in;
          ctx_d      = bus.ct_in;
          r_d        = R_LAST;
          state_d    = ST_WAIT_KEY;
        end
      end
      ST_WAIT_KEY: begin
        if (key_ready[ROUNDS-1]) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Losing the last key means the schedule is being regenerated: start over.
        if (!key_ready[ROUNDS-1]) begin
          {x_d, y_d} = ctx_q;
          r_d        = R_LAST;
          state_d    = ST_WAIT_KEY;
        end else if (key_ready[r_q]) begin
          x_d = rnd_x;
          y_d = rnd_y;
          if (r_q == '0) state_d = ST_DONE;
          else           r_d     = r_q - 1'b1;
        end
      end
      ST_DONE: begin
        // First DONE cycle registers the result; afterwards wait for the consumer.
        if (!pt_valid_q) begin
          pt_out_d   = {x_q, y_q};
          pt_valid_d = 1'b1;
        end else if (bus.pt_ready) begin
          pt_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      ctx_q      <= '0;
      r_q        <= R_LAST;
      pt_out_q   <= '0;
      pt_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      ctx_q      <= ctx_d;
      r_q        <= r_d;
      pt_out_q   <= pt_out_d;
      pt_valid_q <= pt_valid_d;
    end
  end

  assign bus.ct_ready = (state_q == ST_IDLE);
  assign bus.pt_valid = pt_valid_q;
  assign bus.pt_out   = pt_out_q;
  assign busy         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_simon32_decrypt.sv
// Randomized self-checking bench for simon32_decrypt with a forward-cipher reference model.
module tb_simon32_decrypt;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] k_in      [32];
  logic        key_ready [32];
  logic        busy;

  simon32_decrypt_if bus();

  simon32_decrypt dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .k_in      (k_in),
    .key_ready (key_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] rk [32];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] rol(input logic [15:0] v, input int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  function automatic logic [15:0] ror(input logic [15:0] v, input int s);
    return (v >> s) | (v << (16 - s));
  endfunction

  function automatic logic [15:0] fref(input logic [15:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  // SIMON32/64 key schedule from four key words {k3,k2,k1,k0}; also drives the DUT keys.
  task automatic expand(input logic [63:0] key);
    logic [61:0] z = 62'h19C3522FB386A45F;
    logic [15:0] t;
    for (int i = 0; i < 4; i++) rk[i] = key[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t = ror(rk[i-1], 3) ^ rk[i-3];
      t = t ^ ror(t, 1);
      rk[i] = ~rk[i-4] ^ t ^ {15'd0, z[i-4]} ^ 16'd3;
    end
    for (int i = 0; i < 32; i++) k_in[i] = rk[i];
  endtask

  function automatic logic [31:0] encrypt(input logic [31:0] pt);
    logic [15:0] x, y, t;
    {x, y} = pt;
    for (int i = 0; i < 32; i++) begin
      t = x;
      x = y ^ fref(x) ^ rk[i];
      y = t;
    end
    return {x, y};
  endfunction

  task automatic set_ready(input logic v);
    for (int i = 0; i < 32; i++) key_ready[i] = v;
  endtask

  // ---------------- transactions ----------------
  task automatic send(input logic [31:0] ct);
    int w = 0;
    while (!bus.ct_ready && w < 100) begin
      step();
      w++;
    end
    chk("send_ready", {31'd0, bus.ct_ready}, 32'd1);
    bus.ct_valid = 1'b1;
    bus.ct_in    = ct;
    step();
    bus.ct_valid = 1'b0;
  endtask

  // Wait for plaintext, optionally stall the consumer, then take it.
  task automatic recv(input string tag, input logic [31:0] exp, input int hold, output int lat);
    lat = 0;
    while (!bus.pt_valid && lat < 300) begin
      step();
      lat++;
    end
    chk({tag, "_valid"}, {31'd0, bus.pt_valid}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_ctl"}, {29'd0, bus.pt_valid, bus.ct_ready, busy}, 32'b101);
      chk({tag, "_hold_pt"}, bus.pt_out, exp);
    end
    chk({tag, "_pt"}, bus.pt_out, exp);
    bus.pt_ready = 1'b1;
    step();
    bus.pt_ready = 1'b0;
    chk({tag, "_idle"}, {29'd0, bus.pt_valid, bus.ct_ready, busy}, 32'b010);
  endtask

  localparam logic [31:0] VEC_CT = 32'hC69BE9BB;
  localparam logic [31:0] VEC_PT = 32'h65656877;

  initial begin
    int lat;
    int sent, got, extra, idx;
    logic acc;
    logic [31:0] pa, pb, ca, cb, pt;
    logic [31:0] exp_q [$];

    bus.ct_valid = 1'b0;
    bus.ct_in    = '0;
    bus.pt_ready = 1'b0;
    set_ready(1'b1);
    expand(64'h1918_1110_0908_0100);

    // reset with a coincident ciphertext offer
    rst = 1'b1;
    bus.ct_valid = 1'b1;
    bus.ct_in    = VEC_CT;
    step(2);
    chk("rst_ctl", {29'd0, bus.ct_ready, bus.pt_valid, busy}, 32'b100);
    chk("rst_pt", bus.pt_out, 32'd0);
    rst = 1'b0;
    bus.ct_valid = 1'b0;
    step(2);
    chk("rst_noaccept", {31'd0, busy}, 32'd0);

    // known-answer vector, all keys ready
    send(VEC_CT);
    chk("vec_busy", {31'd0, busy}, 32'd1);
    recv("vec", VEC_PT, 0, lat);
    chk("vec_lat", lat, 34);

    // keys still expanding: ready flags rise one per cycle, last one last
    set_ready(1'b0);
    send(VEC_CT);
    step(20);
    chk("wait_ctl", {30'd0, bus.pt_valid, busy}, 32'b01);
    for (int i = 0; i < 32; i++) begin
      key_ready[i] = 1'b1;
      step();
    end
    recv("waitkey", VEC_PT, 0, lat);

    // consumer back-pressure for 10 cycles
    send(VEC_CT);
    recv("hold", VEC_PT, 10, lat);

    // reset in the middle of RUN (round 15 pending)
    send(VEC_CT);
    step(17);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_ctl", {29'd0, bus.ct_ready, bus.pt_valid, busy}, 32'b100);
    send(VEC_CT);
    recv("postrst", VEC_PT, 0, lat);
    chk("postrst_lat", lat, 34);

    // last key drops at round 20 then returns: full restart from round 31
    send(VEC_CT);
    step(12);
    key_ready[31] = 1'b0;
    step(3);
    chk("restart_ctl", {30'd0, bus.pt_valid, busy}, 32'b01);
    key_ready[31] = 1'b1;
    recv("restart", VEC_PT, 0, lat);
    chk("restart_lat", lat, 34);

    // back-to-back blocks, second offered continuously while the first is busy
    expand({$urandom, $urandom});
    pa = $urandom;
    pb = $urandom;
    ca = encrypt(pa);
    cb = encrypt(pb);
    exp_q = {pa, pb};
    bus.pt_ready = 1'b1;
    bus.ct_valid = 1'b1;
    bus.ct_in    = ca;
    sent = 0;
    got  = 0;
    for (int c = 0; c < 200 && got < 2; c++) begin
      if (bus.pt_valid) begin
        if (exp_q.size() > 0) chk("b2b_pt", bus.pt_out, exp_q.pop_front());
        got++;
      end
      acc = bus.ct_ready && bus.ct_valid;
      step();
      if (acc) begin
        sent++;
        if (sent == 1) bus.ct_in = cb;
        else           bus.ct_valid = 1'b0;
      end
    end
    bus.ct_valid = 1'b0;
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus.pt_valid) extra++;
    end
    bus.pt_ready = 1'b0;
    chk("b2b_cnt", {8'd0, got[7:0], sent[7:0], extra[7:0]}, {8'd0, 8'd2, 8'd2, 8'd0});

    // random keys and plaintexts with a random mid-run per-round key stall
    for (int n = 0; n < 4; n++) begin
      expand({$urandom, $urandom});
      pt = $urandom;
      send(encrypt(pt));
      step($urandom_range(2, 25));
      idx = $urandom_range(0, 30);
      key_ready[idx] = 1'b0;
      step($urandom_range(1, 4));
      key_ready[idx] = 1'b1;
      recv("rnd", pt, 0, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/simon32_decrypt.md
SIMON32_DECRYPT -- requirements
Module: simon32_decrypt

Interface
REQ-001 Parameter ROUNDS, default 32, number of SIMON32/64 rounds applied (fixed 32 for this cipher).
REQ-002 Parameter WORD, default 16, word width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ct_valid  input  1  ciphertext block offered.
REQ-006 ct_ready  output  1  block accepted when ct_valid and ct_ready are both high on a rising edge.
REQ-007 ct_in  input  32  ciphertext; bits [31:16] = x word, bits [15:0] = y word.
REQ-008 k_in  input  16 x [31:0] unpacked  round keys from the key expansion block, index = round number.
REQ-009 key_ready  input  1 x [31:0] unpacked  per-round key valid flags from the key expansion block.
REQ-010 pt_valid  output  1  plaintext available.
REQ-011 pt_ready  input  1  consumer accepts plaintext when pt_valid and pt_ready are both high.
REQ-012 pt_out  output  32  plaintext; [31:16] = x, [15:0] = y; stable while pt_valid is high and pt_ready is low.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 States: IDLE, WAIT_KEY, RUN, DONE.
REQ-015 IDLE: ct_ready=1; on handshake, capture ct_in into x/y registers, set round counter r=31, go to WAIT_KEY.
REQ-016 WAIT_KEY: ct_ready=0; when key_ready[31]=1, go to RUN on the next edge; otherwise hold.
REQ-017 RUN: one inverse round per cycle using k_in[r]: new_y = x ^ f(y) ^ k_in[r]; new_x = y; r decrements.
REQ-018 f(v) = (rotl(v,1) & rotl(v,8)) ^ rotl(v,2), 16-bit rotations, no width growth.
REQ-019 RUN stalls (x, y, r held) in any cycle where key_ready[r]=0.
REQ-020 If key_ready[31] drops during RUN, return to WAIT_KEY with r=31 and x/y restored from the captured ciphertext copy.
REQ-021 Round with r=0 completes RUN: go to DONE, load pt_out, pt_valid=1.
REQ-022 Latency with all keys ready: 34 cycles from ct handshake edge to pt_valid high (1 WAIT_KEY + 32 RUN + 1 register).
REQ-023 DONE: hold pt_out/pt_valid until pt_ready=1; on handshake drop pt_valid and go to IDLE (ct_ready high the following cycle).
REQ-024 Round counter is 5 bits; no wrap below 0 (RUN exits on r=0).
REQ-025 No new block is accepted while busy; ct_valid is ignored outside IDLE.

Reset
REQ-026 rst high on any edge forces IDLE regardless of state, including mid-RUN and DONE.
REQ-027 Reset values: ct_ready=1, pt_valid=0, pt_out=0, busy=0, r=31, x=y=0, ciphertext copy=0.
REQ-028 A ct_valid coincident with rst is not accepted.

Structure
REQ-029 Shared package simon_pkg holds ROUNDS, WORD, the 62-bit z0 constant, the state enum type and the f() function, for reuse by the key expansion and encrypt blocks.
REQ-030 One combinational sub-module simon_round_inv (inputs x, y, key; outputs new x, new y) implements REQ-017.
REQ-031 Ciphertext copy register is kept separately from working x/y to support REQ-020.

Verification
REQ-032 Keys k[0..3]=0x0100,0x0908,0x1110,0x1918 expanded, all key_ready high; ct_in=0xC69BE9BB -> pt_out=0x65656877, pt_valid 34 cycles after handshake.
REQ-033 Same ciphertext offered while key_ready[31]=0 (expansion in progress) -> FSM waits in WAIT_KEY, completes with 0x65656877 once key_ready[31] rises.
REQ-034 pt_ready held low 10 cycles after pt_valid -> pt_out stays 0x65656877, ct_ready stays 0; release -> IDLE next cycle.
REQ-035 rst pulsed at RUN round r=15 -> next cycle ct_ready=1, pt_valid=0, busy=0; subsequent block decrypts correctly.
REQ-036 key_ready[31] deasserted at r=20 then reasserted -> rounds restart from 31, final pt_out still 0x65656877.
REQ-037 Back-to-back: two blocks each handshaken as soon as ct_ready is high -> both plaintexts correct, in order, no dropped or duplicated pt_valid.
